// File: rtl/hex_disp_pkg.sv
// Shared definitions for the Avalon-MM seven-segment display slave.
//   - register word addresses
//   - CTRL bit positions
//   - seg_lut(): 4-bit nibble -> 7 active-high segments (bit0=a .. bit6=g)
//   - cnt_width(): counter width for a 0..div-1 prescaler (never below 1)
package hex_disp_pkg;

  localparam logic [3:0] ADDR_DATA     = 4'd0;
  localparam logic [3:0] ADDR_CTRL     = 4'd1;
  localparam logic [3:0] ADDR_BLANK    = 4'd2;
  localparam logic [3:0] ADDR_BLINKM   = 4'd3;
  localparam logic [3:0] ADDR_STATUS   = 4'd4;
  localparam logic [3:0] ADDR_DP       = 4'd5;
  localparam logic [3:0] ADDR_RAW_BASE = 4'd8;

  localparam int CTRL_DECODE   = 0;
  localparam int CTRL_BLINK_EN = 1;

  function automatic logic [6:0] seg_lut(input logic [3:0] nibble);
    logic [6:0] seg;
    case (nibble)
      4'h0: seg = 7'h3F;
      4'h1: seg = 7'h06;
      4'h2: seg = 7'h5B;
      4'h3: seg = 7'h4F;
      4'h4: seg = 7'h66;
      4'h5: seg = 7'h6D;
      4'h6: seg = 7'h7D;
      4'h7: seg = 7'h07;
      4'h8: seg = 7'h7F;
      4'h9: seg = 7'h6F;
      4'hA: seg = 7'h77;
      4'hB: seg = 7'h7C;
      4'hC: seg = 7'h39;
      4'hD: seg = 7'h5E;
      4'hE: seg = 7'h79;
      default: seg = 7'h71;
    endcase
    return seg;
  endfunction

  function automatic int cnt_width(input int div);
    return (div <= 2) ? 1 : $clog2(div);
  endfunction

endpackage

// File: rtl/hex_seg_decoder.sv
// Combinational hex digit decoder.
//   nibble    in  4  hex value 0..F
//   segments  out 7  active-high segments, bit0=a .. bit6=g
module hex_seg_decoder
  import hex_disp_pkg::*;
(
  input  logic [3:0] nibble,
  output logic [6:0] segments
);

  assign segments = seg_lut(nibble);

endmodule

// File: rtl/avalon_hex_display.sv
// Avalon-MM slave driving NUM_DIGITS seven-segment digits with per-digit hex
// decode or raw segments, blanking, timed blinking and optional decimal points.
//   clk, reset_n             clock, asynchronous active-low reset
//   address/chipselect/
//   write_n/writedata        Avalon-MM slave write port, zero wait states
//   readdata                 combinational read data selected by address
//   hex_out                  registered segments, digit i at [i*SEG_W +: SEG_W]
//   blink_phase              1 while blinking digits are dark
// Build option: define HEX_DISP_DP_EN to add the DP register (address 5) and
// an eighth segment bit per digit; otherwise SEG_W is 7 and address 5 is unused.
module avalon_hex_display
  import hex_disp_pkg::*;
#(
  parameter int NUM_DIGITS = 6,
  parameter int CLK_HZ     = 50_000_000,
  parameter int BLINK_HZ   = 2,
  parameter bit ACTIVE_LOW = 1'b1,
`ifdef HEX_DISP_DP_EN
  localparam int SEG_W     = 8
`else
  localparam int SEG_W     = 7
`endif
)
(
  input  logic                        clk,
  input  logic                        reset_n,
  input  logic [3:0]                  address,
  input  logic                        chipselect,
  input  logic                        write_n,
  input  logic [31:0]                 writedata,
  output logic [31:0]                 readdata,
  output logic [NUM_DIGITS*SEG_W-1:0] hex_out,
  output logic                        blink_phase
);

  localparam int               BLINK_DIV = CLK_HZ / (2 * BLINK_HZ);
  localparam int               CNT_W     = cnt_width(BLINK_DIV);
  localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(BLINK_DIV - 1);
  localparam logic [SEG_W-1:0] SEG_OFF   = ACTIVE_LOW ? {SEG_W{1'b1}} : {SEG_W{1'b0}};

  logic                    wr;
  logic [4*NUM_DIGITS-1:0] data_reg;
  logic [1:0]              ctrl_reg;
  logic [NUM_DIGITS-1:0]   blank_reg;
  logic [NUM_DIGITS-1:0]   blinkm_reg;
  logic [6:0]              raw_reg [NUM_DIGITS];
`ifdef HEX_DISP_DP_EN
  logic [NUM_DIGITS-1:0]   dp_reg;
`endif
  logic [CNT_W-1:0]        blink_cnt;
  logic                    phase;
  logic                    blink_clr;
  logic [6:0]              lut_seg [NUM_DIGITS];
  logic [SEG_W-1:0]        field;
  logic                    dark;
  logic [NUM_DIGITS*SEG_W-1:0] hex_next;

  assign wr = chipselect & ~write_n;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      data_reg   <= '0;
      ctrl_reg   <= 2'b01;
      blank_reg  <= '1;
      blinkm_reg <= '0;
`ifdef HEX_DISP_DP_EN
      dp_reg     <= '0;
`endif
      for (int i = 0; i < NUM_DIGITS; i++) raw_reg[i] <= '0;
    end else if (wr) begin
      case (address)
        ADDR_DATA:   data_reg   <= writedata[4*NUM_DIGITS-1:0];
        ADDR_CTRL:   ctrl_reg   <= writedata[1:0];
        ADDR_BLANK:  blank_reg  <= writedata[NUM_DIGITS-1:0];
        ADDR_BLINKM: blinkm_reg <= writedata[NUM_DIGITS-1:0];
`ifdef HEX_DISP_DP_EN
        ADDR_DP:     dp_reg     <= writedata[NUM_DIGITS-1:0];
`endif
        default: ;
      endcase
      for (int i = 0; i < NUM_DIGITS; i++) begin
        if (address == ADDR_RAW_BASE + 4'(i)) raw_reg[i] <= writedata[6:0];
      end
    end
  end

  // A CTRL write that clears BLINK_EN takes effect on the same edge, even if
  // the prescaler is at terminal count, so the phase can never flip on the way out.
  assign blink_clr = wr && (address == ADDR_CTRL) && !writedata[CTRL_BLINK_EN];

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      blink_cnt <= '0;
      phase     <= 1'b0;
    end else if (!ctrl_reg[CTRL_BLINK_EN] || blink_clr) begin
      blink_cnt <= '0;
      phase     <= 1'b0;
    end else if (blink_cnt == CNT_LAST) begin
      blink_cnt <= '0;
      phase     <= ~phase;
    end else begin
      blink_cnt <= blink_cnt + 1'b1;
    end
  end

  assign blink_phase = phase;

  for (genvar g = 0; g < NUM_DIGITS; g++) begin : g_dec
    hex_seg_decoder u_dec (
      .nibble   (data_reg[4*g +: 4]),
      .segments (lut_seg[g])
    );
  end

  // Per digit: blank beats blink, blink beats content; dp shares the gating.
  always_comb begin
    hex_next = '0;
    field    = '0;
    dark     = 1'b0;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      dark       = blank_reg[i] | (ctrl_reg[CTRL_BLINK_EN] & blinkm_reg[i] & phase);
      field      = '0;
      field[6:0] = ctrl_reg[CTRL_DECODE] ? lut_seg[i] : raw_reg[i];
`ifdef HEX_DISP_DP_EN
      field[7]   = dp_reg[i];
`endif
      if (dark) field = '0;
      hex_next[i*SEG_W +: SEG_W] = ACTIVE_LOW ? ~field : field;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) hex_out <= {NUM_DIGITS{SEG_OFF}};
    else          hex_out <= hex_next;
  end

  always_comb begin
    readdata = '0;
    case (address)
      ADDR_DATA:   readdata = 32'(data_reg);
      ADDR_CTRL:   readdata = 32'(ctrl_reg);
      ADDR_BLANK:  readdata = 32'(blank_reg);
      ADDR_BLINKM: readdata = 32'(blinkm_reg);
      ADDR_STATUS: readdata = 32'(phase);
`ifdef HEX_DISP_DP_EN
      ADDR_DP:     readdata = 32'(dp_reg);
`endif
      default: begin
        if (address[3] && (int'(address[2:0]) < NUM_DIGITS))
          readdata = 32'(raw_reg[address[2:0]]);
      end
    endcase
  end

endmodule

// File: tb/tb_avalon_hex_display.sv
module tb_avalon_hex_display;

  localparam int NUM_DIGITS = 6;
  localparam int CLK_HZ     = 8;
  localparam int BLINK_HZ   = 1;
  localparam int BLINK_DIV  = CLK_HZ / (2 * BLINK_HZ);
`ifdef HEX_DISP_DP_EN
  localparam int SEG_W = 8;
  localparam logic [31:0] DP_READ = 32'h15;
`else
  localparam int SEG_W = 7;
  localparam logic [31:0] DP_READ = 32'h0;
`endif
  localparam int HW = NUM_DIGITS * SEG_W;

  localparam logic [6:0] LUT [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                                      7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};

  logic          clk = 1'b0;
  logic          reset_n;
  logic [3:0]    address;
  logic          chipselect;
  logic          write_n;
  logic [31:0]   writedata;
  logic [31:0]   readdata;
  logic [HW-1:0] hex_out;
  logic          blink_phase;

  avalon_hex_display #(
    .NUM_DIGITS (NUM_DIGITS),
    .CLK_HZ     (CLK_HZ),
    .BLINK_HZ   (BLINK_HZ),
    .ACTIVE_LOW (1'b1)
  ) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .address     (address),
    .chipselect  (chipselect),
    .write_n     (write_n),
    .writedata   (writedata),
    .readdata    (readdata),
    .hex_out     (hex_out),
    .blink_phase (blink_phase)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  // Reference model: register contents plus "edges spent enabled" for blinking.
  logic [23:0]   m_data;
  logic [1:0]    m_ctrl;
  logic [5:0]    m_blank, m_blinkm, m_dp;
  logic [6:0]    m_raw [NUM_DIGITS];
  int            m_en_cycles;
  logic [HW-1:0] exp_hex;

  function automatic logic m_phase();
    return ((m_en_cycles / BLINK_DIV) % 2) == 1;
  endfunction

  function automatic logic [HW-1:0] model_hex();
    logic [HW-1:0] v;
    logic [7:0] f;
    v = '0;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      f = {1'b0, m_ctrl[0] ? LUT[m_data[4*i +: 4]] : m_raw[i]};
`ifdef HEX_DISP_DP_EN
      f[7] = m_dp[i];
`endif
      if (m_blank[i] || (m_ctrl[1] && m_blinkm[i] && m_phase())) f = 8'h00;
      v[i*SEG_W +: SEG_W] = ~f[SEG_W-1:0];
    end
    return v;
  endfunction

  function automatic logic [31:0] model_read(input logic [3:0] a);
    int ai;
    ai = int'(a);
    if (ai == 0) return 32'(m_data);
    if (ai == 1) return 32'(m_ctrl);
    if (ai == 2) return 32'(m_blank);
    if (ai == 3) return 32'(m_blinkm);
    if (ai == 4) return 32'(m_phase());
`ifdef HEX_DISP_DP_EN
    if (ai == 5) return 32'(m_dp);
`endif
    if (ai >= 8 && ai - 8 < NUM_DIGITS) return 32'(m_raw[ai - 8]);
    return 32'h0;
  endfunction

  task automatic model_reset();
    m_data = '0; m_ctrl = 2'b01; m_blank = '1; m_blinkm = '0; m_dp = '0;
    for (int i = 0; i < NUM_DIGITS; i++) m_raw[i] = '0;
    m_en_cycles = 0;
    exp_hex = '1;
  endtask

  task automatic model_edge();
    logic w;
    int ai;
    w  = chipselect & ~write_n;
    ai = int'(address);
    exp_hex = model_hex();
    if (!m_ctrl[1] || (w && ai == 1 && !writedata[1])) m_en_cycles = 0;
    else m_en_cycles++;
    if (w) begin
      if (ai == 0) m_data = writedata[23:0];
      if (ai == 1) m_ctrl = writedata[1:0];
      if (ai == 2) m_blank = writedata[5:0];
      if (ai == 3) m_blinkm = writedata[5:0];
`ifdef HEX_DISP_DP_EN
      if (ai == 5) m_dp = writedata[5:0];
`endif
      if (ai >= 8 && ai - 8 < NUM_DIGITS) m_raw[ai - 8] = writedata[6:0];
    end
  endtask

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge();
    @(negedge clk);
    check("hex_out", 64'(hex_out), 64'(exp_hex));
    check("blink_phase", 64'(blink_phase), 64'(m_phase()));
  endtask

  task automatic bus_write(input logic [3:0] a, input logic [31:0] d);
    address = a; writedata = d; chipselect = 1'b1; write_n = 1'b0;
    tick();
    chipselect = 1'b0; write_n = 1'b1;
  endtask

  task automatic read_const(input string name, input logic [3:0] a, input logic [31:0] exp);
    address = a;
    #1;
    check(name, 64'(readdata), 64'(exp));
  endtask

  function automatic logic [SEG_W-1:0] digit(input int i);
    return hex_out[i*SEG_W +: SEG_W];
  endfunction

  typedef struct {
    logic [3:0]  addr;
    logic [31:0] wdata;
    logic [31:0] exp_read;
  } vec_t;

  vec_t vecs [15];

  initial begin
    bit found;

    vecs[0]  = '{4'd0,  32'hFFFF_FFFF, 32'h00FF_FFFF};
    vecs[1]  = '{4'd1,  32'hFFFF_FFFD, 32'h1};
    vecs[2]  = '{4'd2,  32'hFFFF_FFC0, 32'h0};
    vecs[3]  = '{4'd3,  32'h0000_00AA, 32'h2A};
    vecs[4]  = '{4'd4,  32'h0000_00FF, 32'h0};
    vecs[5]  = '{4'd5,  32'h0000_0015, DP_READ};
    vecs[6]  = '{4'd6,  32'h0000_0001, 32'h0};
    vecs[7]  = '{4'd7,  32'h0000_FFFF, 32'h0};
    vecs[8]  = '{4'd8,  32'h0000_FFFF, 32'h7F};
    vecs[9]  = '{4'd13, 32'h0000_0012, 32'h12};
    vecs[10] = '{4'd14, 32'h0000_0055, 32'h0};
    vecs[11] = '{4'd15, 32'h0000_0077, 32'h0};
    vecs[12] = '{4'd2,  32'h0000_003F, 32'h3F};
    vecs[13] = '{4'd1,  32'h0000_0000, 32'h0};
    vecs[14] = '{4'd1,  32'h0000_0001, 32'h1};

    reset_n = 1'b0; address = '0; chipselect = 1'b0; write_n = 1'b1; writedata = '0;
    model_reset();
    @(negedge clk);
    check("rst_hex", 64'(hex_out), 64'({HW{1'b1}}));
    check("rst_phase", 64'(blink_phase), 64'(0));
    read_const("rst_ctrl", 4'd1, 32'h1);
    read_const("rst_blank", 4'd2, 32'h3F);
    @(negedge clk);
    reset_n = 1'b1;
    tick();

    // register map table
    for (int v = 0; v < 15; v++) begin
      bus_write(vecs[v].addr, vecs[v].wdata);
      read_const($sformatf("regmap_%0d", v), vecs[v].addr, vecs[v].exp_read);
    end

    // decoded digits
    bus_write(4'd2, 32'h0);
    bus_write(4'd0, 32'h12);
    tick();
    check("dec_d0", 64'(digit(0)), 64'(7'h24));
    check("dec_d1", 64'(digit(1)), 64'(7'h79));
    check("dec_d2", 64'(digit(2)), 64'(7'h40));

    // raw mode
    bus_write(4'd1, 32'h0);
    bus_write(4'd8, 32'h49);
    tick();
    check("raw_d0", 64'(digit(0)), 64'(7'h36));
    read_const("raw_rd8", 4'd8, 32'h49);
    read_const("raw_rd14", 4'd14, 32'h0);

    // blinking: phase flips every BLINK_DIV edges after the enabling write
    bus_write(4'd0, 32'h10);
    bus_write(4'd3, 32'h01);
    bus_write(4'd1, 32'h3);
    for (int k = 1; k <= 12; k++) begin
      tick();
      check("blink_phase_seq", 64'(blink_phase), 64'((k / 4) % 2));
      check("blink_d0", 64'(digit(0)), 64'((((k - 1) / 4) % 2) == 1 ? 7'h7F : 7'h40));
      check("blink_d1", 64'(digit(1)), 64'(7'h79));
    end

    // clear BLINK_EN on a terminal-count edge while phase is 0
    found = 1'b0;
    for (int k = 0; k < 10 && !found; k++) begin
      if ((m_en_cycles % (2 * BLINK_DIV)) == BLINK_DIV - 1) found = 1'b1;
      else tick();
    end
    check("tc_found", 64'(found), 64'(1));
    bus_write(4'd1, 32'h1);
    check("tc_clear_phase", 64'(blink_phase), 64'(0));
    for (int k = 0; k < 5; k++) begin
      tick();
      check("tc_hold_phase", 64'(blink_phase), 64'(0));
    end
    bus_write(4'd1, 32'h3);
    for (int k = 0; k < 3; k++) tick();
    check("reen_phase_low", 64'(blink_phase), 64'(0));
    tick();
    check("reen_phase_high", 64'(blink_phase), 64'(1));

    // randomized traffic
    for (int n = 0; n < 400; n++) begin
      address    = 4'($urandom_range(0, 15));
      writedata  = $urandom;
      chipselect = 1'($urandom_range(0, 1));
      write_n    = 1'($urandom_range(0, 1));
      #1;
      check("rand_read", 64'(readdata), 64'(model_read(address)));
      tick();
    end
    chipselect = 1'b0; write_n = 1'b1;

    // asynchronous reset in the middle of blinking
    bus_write(4'd2, 32'h0);
    bus_write(4'd0, 32'hABCDEF);
    bus_write(4'd3, 32'h3F);
    bus_write(4'd1, 32'h3);
    for (int k = 0; k < 6; k++) tick();
    #2;
    reset_n = 1'b0;
    #1;
    model_reset();
    check("arst_hex", 64'(hex_out), 64'({HW{1'b1}}));
    check("arst_phase", 64'(blink_phase), 64'(0));
    read_const("arst_data", 4'd0, 32'h0);
    @(negedge clk);
    reset_n = 1'b1;
    tick();
    read_const("post_rst_ctrl", 4'd1, 32'h1);

`ifdef HEX_DISP_DP_EN
    bus_write(4'd2, 32'h0);
    bus_write(4'd5, 32'h01);
    bus_write(4'd0, 32'h8);
    tick();
    check("dp_on_d0", 64'(digit(0)), 64'(8'h00));
    bus_write(4'd2, 32'h1);
    tick();
    check("dp_blank_d0", 64'(digit(0)), 64'(8'hFF));
`endif

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
